// File: rtl/ble_packet_receiver.sv
// BLE receive path: preamble/access-address sync search on the demodulated bit
// stream, header/payload byte capture, and 24-bit CRC check.
module ble_packet_receiver #(
   parameter logic [31:0] ACCESS_ADDR = 32'h8E89BED6,
   parameter logic [23:0] CRC_INIT    = 24'h555555,
   parameter int unsigned MAX_LEN     = 37
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en_i,
   input  logic       symVal_i,
   input  logic       symValid_i,
   output logic       syncFound_o,
   output logic [7:0] rxByte_o,
   output logic       rxByteValid_o,
   output logic [7:0] rxLen_o,
   output logic       pktDone_o,
   output logic       crcOk_o,
   output logic       lenErr_o
);
   localparam logic [7:0]  PRE  = ACCESS_ADDR[0] ? 8'h55 : 8'hAA;
   localparam logic [39:0] SYNC = {ACCESS_ADDR, PRE};
   localparam logic [23:0] POLY = 24'h00065B;
   localparam logic [7:0]  MAXL = 8'(MAX_LEN);

   typedef enum logic [1:0] {HUNT, HDR, PAYLOAD, CRC} state_t;

   state_t      state_q, state_d;
   logic [39:0] sreg_q, sreg_d, sreg_sh;
   logic [23:0] crc_q, crc_d, crc_nxt;
   logic [7:0]  sh_q, sh_d, byte_sh;
   logic [2:0]  bitcnt_q, bitcnt_d;
   logic [7:0]  bytecnt_q, bytecnt_d;
   logic [4:0]  crccnt_q, crccnt_d;
   logic        crcerr_q, crcerr_d;
   logic        fb, mis;
   logic [7:0]  rxByte_q, rxByte_d, rxLen_q, rxLen_d;
   logic        rxByteValid_q, rxByteValid_d, pktDone_q, pktDone_d;
   logic        crcOk_q, crcOk_d, lenErr_q, lenErr_d, syncFound_q, syncFound_d;

   always_comb begin
      state_d       = state_q;
      sreg_d        = sreg_q;
      crc_d         = crc_q;
      sh_d          = sh_q;
      bitcnt_d      = bitcnt_q;
      bytecnt_d     = bytecnt_q;
      crccnt_d      = crccnt_q;
      crcerr_d      = crcerr_q;
      rxByte_d      = rxByte_q;
      rxLen_d       = rxLen_q;
      crcOk_d       = crcOk_q;
      rxByteValid_d = 1'b0;
      pktDone_d     = 1'b0;
      lenErr_d      = 1'b0;
      syncFound_d   = 1'b0;
      sreg_sh       = {symVal_i, sreg_q[39:1]};
      byte_sh       = {symVal_i, sh_q[7:1]};
      fb            = crc_q[23] ^ symVal_i;
      crc_nxt       = {crc_q[22:0], 1'b0} ^ (fb ? POLY : 24'h0);
      mis           = symVal_i ^ crc_q[5'd23 - crccnt_q];

      if (!en_i) begin
         state_d   = HUNT;
         sreg_d    = '0;
         bitcnt_d  = '0;
         bytecnt_d = '0;
         crccnt_d  = '0;
         crcerr_d  = 1'b0;
      end else if (symValid_i) begin
         unique case (state_q)
            HUNT: begin
               if (sreg_sh == SYNC) begin
                  syncFound_d = 1'b1;
                  sreg_d      = '0;
                  crc_d       = CRC_INIT;
                  crcOk_d     = 1'b0;
                  rxLen_d     = '0;
                  bitcnt_d    = '0;
                  bytecnt_d   = '0;
                  crccnt_d    = '0;
                  crcerr_d    = 1'b0;
                  state_d     = HDR;
               end else begin
                  sreg_d = sreg_sh;
               end
            end
            HDR, PAYLOAD: begin
               crc_d    = crc_nxt;
               sh_d     = byte_sh;
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) begin
                  rxByte_d      = byte_sh;
                  rxByteValid_d = 1'b1;
                  bytecnt_d     = bytecnt_q + 8'd1;
                  if (state_q == HDR) begin
                     if (bytecnt_q == 8'd1) begin
                        // second header byte is the payload length
                        rxLen_d   = byte_sh;
                        bytecnt_d = '0;
                        if (byte_sh > MAXL) begin
                           lenErr_d = 1'b1;
                           state_d  = HUNT;
                        end else if (byte_sh == 8'd0) begin
                           state_d = CRC;
                        end else begin
                           state_d = PAYLOAD;
                        end
                     end
                  end else if (bytecnt_q + 8'd1 == rxLen_q) begin
                     state_d = CRC;
                  end
               end
            end
            CRC: begin
               crcerr_d = crcerr_q | mis;
               crccnt_d = crccnt_q + 5'd1;
               if (crccnt_q == 5'd23) begin
                  pktDone_d = 1'b1;
                  crcOk_d   = ~(crcerr_q | mis);
                  crccnt_d  = '0;
                  state_d   = HUNT;
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= HUNT;
         sreg_q        <= '0;
         crc_q         <= CRC_INIT;
         sh_q          <= '0;
         bitcnt_q      <= '0;
         bytecnt_q     <= '0;
         crccnt_q      <= '0;
         crcerr_q      <= 1'b0;
         rxByte_q      <= '0;
         rxLen_q       <= '0;
         crcOk_q       <= 1'b0;
         rxByteValid_q <= 1'b0;
         pktDone_q     <= 1'b0;
         lenErr_q      <= 1'b0;
         syncFound_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         sreg_q        <= sreg_d;
         crc_q         <= crc_d;
         sh_q          <= sh_d;
         bitcnt_q      <= bitcnt_d;
         bytecnt_q     <= bytecnt_d;
         crccnt_q      <= crccnt_d;
         crcerr_q      <= crcerr_d;
         rxByte_q      <= rxByte_d;
         rxLen_q       <= rxLen_d;
         crcOk_q       <= crcOk_d;
         rxByteValid_q <= rxByteValid_d;
         pktDone_q     <= pktDone_d;
         lenErr_q      <= lenErr_d;
         syncFound_q   <= syncFound_d;
      end
   end

   assign syncFound_o   = syncFound_q;
   assign rxByte_o      = rxByte_q;
   assign rxByteValid_o = rxByteValid_q;
   assign rxLen_o       = rxLen_q;
   assign pktDone_o     = pktDone_q;
   assign crcOk_o       = crcOk_q;
   assign lenErr_o      = lenErr_q;
endmodule

// File: tb/tb_ble_packet_receiver.sv
// Bench for ble_packet_receiver: table-driven packets, hand-written corner cases
// and random packets checked against a bit-queue reference model.
module tb_ble_packet_receiver;
   localparam logic [31:0] AA = 32'h8E89BED6;

   logic       clk = 1'b0, rst = 1'b0, en_i = 1'b1, symVal_i = 1'b0, symValid_i = 1'b0;
   logic       syncFound_o, rxByteValid_o, pktDone_o, crcOk_o, lenErr_o;
   logic [7:0] rxByte_o, rxLen_o;

   always #5 clk = ~clk;

   ble_packet_receiver dut (
      .clk(clk), .rst(rst), .en_i(en_i), .symVal_i(symVal_i), .symValid_i(symValid_i),
      .syncFound_o(syncFound_o), .rxByte_o(rxByte_o), .rxByteValid_o(rxByteValid_o),
      .rxLen_o(rxLen_o), .pktDone_o(pktDone_o), .crcOk_o(crcOk_o), .lenErr_o(lenErr_o)
   );

   int n_chk = 0, n_fail = 0;
   int m_sync = 0, m_done = 0, m_lenerr = 0, scnt = 0, sync_at = 0, done_at = 0;
   logic [7:0] got[$];
   logic [7:0] exp_b[$];
   bit pk[$];

   // pulses are stamped with the number of strobes seen before the current cycle
   always @(negedge clk) begin
      if (syncFound_o) begin m_sync++; sync_at = scnt; end
      if (rxByteValid_o) got.push_back(rxByte_o);
      if (pktDone_o) begin m_done++; done_at = scnt; end
      if (lenErr_o) m_lenerr++;
      if (symValid_i) scnt++;
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic push_byte(input logic [7:0] b);
      for (int i = 0; i < 8; i++) pk.push_back(b[i]);
   endtask

   function automatic int crc_of(input int nbits);
      int c = 'h555555;
      for (int i = 0; i < nbits; i++) begin
         int fbit;
         fbit = ((c >> 23) & 1) ^ int'(pk[i]);
         c = ((c << 1) & 'hFFFFFF) ^ (fbit != 0 ? 'h65B : 0);
      end
      return c;
   endfunction

   // header 0x02,len, payload, CRC sent MSB of the register first; optional channel bit error
   task automatic build(input int len, input bit rnd, input int flip);
      int c;
      pk.delete();
      push_byte(8'h02);
      push_byte(8'(len));
      if (len <= 37) begin
         for (int i = 0; i < len; i++) push_byte(rnd ? 8'($urandom) : 8'(i + 1));
         c = crc_of(pk.size());
         for (int i = 23; i >= 0; i--) pk.push_back(c[i]);
      end
      if (flip >= 0) pk[flip] = ~pk[flip];
   endtask

   task automatic ref_model(input int len, output int nb, output int ok);
      int rc;
      logic [7:0] v;
      nb = (len > 37) ? 2 : 2 + len;
      exp_b.delete();
      for (int k = 0; k < nb; k++) begin
         for (int i = 0; i < 8; i++) v[i] = pk[8*k + i];
         exp_b.push_back(v);
      end
      ok = 0;
      if (len <= 37) begin
         rc = 0;
         for (int i = 0; i < 24; i++) rc = (rc << 1) | int'(pk[8*nb + i]);
         ok = (rc == crc_of(8*nb)) ? 1 : 0;
      end
   endtask

   task automatic send_bit(input bit b, input int gap);
      symVal_i = b; symValid_i = 1'b1;
      @(posedge clk); #1;
      symValid_i = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
   endtask

   task automatic send_sync(input int flipbit, input int gap);
      logic [39:0] s;
      s = {AA, 8'hAA};
      if (flipbit >= 0) s[flipbit] = ~s[flipbit];
      for (int i = 0; i < 40; i++) send_bit(s[i], gap);
   endtask

   task automatic settle();
      repeat (4) begin @(posedge clk); #1; end
   endtask

   // negative exp_n / exp_ok mean "take it from the reference model"
   task automatic run_pkt(input string nm, input int len, input int gap, input int exp_n,
                          input int exp_done, input int exp_ok, input int exp_le);
      int s0, d0, l0, g0, nb, mok;
      s0 = m_sync; d0 = m_done; l0 = m_lenerr; g0 = got.size();
      ref_model(len, nb, mok);
      send_sync(-1, gap);
      foreach (pk[i]) send_bit(pk[i], gap);
      settle();
      chk({nm, " sync"}, m_sync - s0, 1);
      chk({nm, " nbytes"}, got.size() - g0, exp_n < 0 ? nb : exp_n);
      for (int k = 0; k < nb && g0 + k < got.size(); k++) chk({nm, " byte"}, got[g0+k], exp_b[k]);
      chk({nm, " done"}, m_done - d0, exp_done);
      chk({nm, " lenErr"}, m_lenerr - l0, exp_le);
      chk({nm, " rxLen"}, rxLen_o, len & 255);
      chk({nm, " crcOk"}, crcOk_o, exp_ok < 0 ? mok : exp_ok);
      if (exp_done != 0) chk({nm, " span"}, done_at - sync_at, 40 + 8*len);
   endtask

   typedef struct {
      int len; int flip; int gap; int en_drop;
      int exp_n; int exp_done; int exp_ok; int exp_le;
   } vec_t;
   vec_t tbl[9];

   initial begin
      int s0, len, flip, gap, nb, mok;
      tbl[0] = '{6,  -1, 0, 0, 8,  1, 1, 0};
      tbl[1] = '{6,  33, 0, 0, 8,  1, 0, 0};
      tbl[2] = '{48, -1, 0, 0, 2,  0, 0, 1};
      tbl[3] = '{6,  -1, 0, 0, 8,  1, 1, 0};
      tbl[4] = '{0,  -1, 2, 1, 2,  1, 1, 0};
      tbl[5] = '{37, -1, 0, 0, 39, 1, 1, 0};
      tbl[6] = '{38, -1, 1, 0, 2,  0, 0, 1};
      tbl[7] = '{3,  45, 0, 0, 5,  1, 0, 0};
      tbl[8] = '{1,  16, 1, 0, 3,  1, 0, 0};

      #2 rst = 1'b1;
      #10;
      chk("reset syncFound", syncFound_o, 0);
      chk("reset rxByteValid", rxByteValid_o, 0);
      chk("reset rxByte", rxByte_o, 0);
      chk("reset rxLen", rxLen_o, 0);
      chk("reset pktDone", pktDone_o, 0);
      chk("reset crcOk", crcOk_o, 0);
      chk("reset lenErr", lenErr_o, 0);
      @(posedge clk); #1 rst = 1'b0;
      settle();

      foreach (tbl[r]) begin
         build(tbl[r].len, 1'b0, tbl[r].flip);
         if (tbl[r].en_drop != 0) begin
            en_i = 1'b0; @(posedge clk); #1; en_i = 1'b1;
         end
         run_pkt($sformatf("vec%0d", r), tbl[r].len, tbl[r].gap, tbl[r].exp_n,
                 tbl[r].exp_done, tbl[r].exp_ok, tbl[r].exp_le);
      end

      // en low between bit 39 and 40 of the sync word must wipe the partial match
      s0 = m_sync;
      begin
         logic [39:0] s;
         s = {AA, 8'hAA};
         for (int i = 0; i < 39; i++) send_bit(s[i], 0);
         en_i = 1'b0; @(posedge clk); #1; en_i = 1'b1;
         send_bit(s[39], 0);
      end
      settle();
      chk("en clears sreg", m_sync - s0, 0);
      build(6, 1'b0, -1);
      run_pkt("after en", 6, 0, -1, 1, 1, 0);

      // asynchronous reset in the middle of a payload
      build(6, 1'b0, -1);
      send_sync(-1, 0);
      for (int i = 0; i < 40; i++) send_bit(pk[i], 0);
      #3 rst = 1'b1;
      #1;
      chk("midrst rxLen", rxLen_o, 0);
      chk("midrst rxByte", rxByte_o, 0);
      chk("midrst crcOk", crcOk_o, 0);
      chk("midrst pulses", {syncFound_o, rxByteValid_o, pktDone_o, lenErr_o}, 0);
      @(posedge clk); #1 rst = 1'b0;
      settle();
      build(6, 1'b0, -1);
      run_pkt("after rst", 6, 0, -1, 1, 1, 0);

      // noise, corrupted access address, then the real packet
      s0 = m_sync;
      for (int i = 0; i < 100; i++) send_bit(1'($urandom), 0);
      send_sync(13, 0);
      settle();
      chk("corrupt AA sync", m_sync - s0, 0);
      build(6, 1'b0, -1);
      run_pkt("after corrupt", 6, 0, -1, 1, 1, 0);

      for (int p = 0; p < 20; p++) begin
         len  = $urandom_range(0, 37);
         flip = ($urandom_range(0, 3) == 0) ? $urandom_range(16, 16 + 8*len + 23) : -1;
         gap  = $urandom_range(0, 2);
         build(len, 1'b1, flip);
         ref_model(len, nb, mok);
         if (flip >= 0) chk($sformatf("rnd%0d model flags error", p), mok, 0);
         run_pkt($sformatf("rnd%0d", p), len, gap, -1, 1, -1, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL timeout: simulation did not finish, limit 5000000 ns reached");
      $fatal(1);
   end
endmodule

// File: doc/ble_packet_receiver.md
# ble_packet_receiver

Receive-side counterpart of the BLE packet generator. It consumes the demodulated symbol stream (one bit per strobe, air order) and hunts for the preamble plus access address. Once synchronised, it captures the 2-byte PDU header and the payload, emitting each as a byte stream, then checks the 24-bit BLE CRC. It sits between the FSK demodulator/bit-slicer and the link-layer consumer.

## Interface
- ACCESS_ADDR, 32'h8E89BED6: access address to match; air order is LSB first.
- CRC_INIT, 24'h555555: CRC register preset, loaded at sync.
- MAX_LEN, 37: largest accepted payload length in bytes.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  receiver enable; low forces HUNT synchronously and clears the sync register.
- symVal  in  1  demodulated bit; valid only when symValid=1.
- symValid  in  1  one-cycle strobe, one per received bit.
- syncFound  out  1  one-cycle pulse on preamble+AA match.
- rxByte  out  8  captured header/payload byte; bit 0 is the first bit received.
- rxByteValid  out  1  one-cycle pulse qualifying rxByte.
- rxLen  out  8  payload length from header byte 1; held until the next sync.
- pktDone  out  1  one-cycle pulse after the last CRC bit.
- crcOk  out  1  CRC result; valid with pktDone and held until the next sync.
- lenErr  out  1  one-cycle pulse when rxLen > MAX_LEN.

## Operation
- Reset: state=HUNT; all outputs 0; sync register 0; CRC register = CRC_INIT; all counters 0.
- States: HUNT -> HDR -> PAYLOAD -> CRC -> HUNT.
- Every action below happens only on cycles with symValid=1. With symValid=0, all state holds.
- HUNT:
  - The 40-bit sync register shifts right, with the new bit entering bit 39.
  - Match condition: sreg[39:8]==ACCESS_ADDR and sreg[7:0]==PRE, where PRE = ACCESS_ADDR[0] ? 8'h55 : 8'hAA.
  - On match: pulse syncFound, clear sreg, preset the CRC register to CRC_INIT, clear crcOk and rxLen, go to HDR.
- HDR and PAYLOAD:
  - Bits assemble LSB first into an 8-bit shift register, tracked by a 3-bit bit counter.
  - Each data bit d updates the CRC: fb=c[23]^d; c={c[22:0],1'b0} ^ (fb ? 24'h00065B : 0).
  - Each completed byte is output on rxByte with an rxByteValid pulse.
  - HDR covers 2 bytes. When the 2nd byte completes, rxLen takes that byte.
  - If the 2nd byte > MAX_LEN: pulse lenErr, go to HUNT, and assert no pktDone.
  - Else if the 2nd byte == 0: go to CRC.
  - Else: go to PAYLOAD.
- PAYLOAD: an 8-bit byte counter runs until rxLen bytes are emitted, then goes to CRC.
- CRC:
  - The CRC register is frozen.
  - Received CRC bit i (i=0..23) is compared with c[23-i]; any mismatch sets a sticky error flag.
  - After bit 23: pulse pktDone, set crcOk = no mismatch, go to HUNT.
- en=0 overrides everything except rst: go to HUNT, clear sreg, no pulses. rxLen and crcOk hold.
- rst mid-packet aborts immediately and asynchronously; partial data is discarded.
- Sync search runs only in HUNT. Bits that arrive in other states never enter sreg, so a new packet always needs a full 40-bit preamble+AA.

## Timing
- All outputs are registered.
- Each pulse appears in the cycle after the symValid strobe that causes it:
  - syncFound after the 40th matching bit;
  - rxByteValid after the 8th bit of a byte;
  - pktDone/crcOk after the 24th CRC bit;
  - lenErr after the 16th header bit.
- rxByte is stable while rxByteValid=1 and holds until the next byte.
- Strobes may be back-to-back on every cycle with no loss. Throughput is 1 bit/cycle.
- The cycle after the last CRC strobe is already HUNT; a strobe in that cycle is shifted into sreg.
- Packet length in bits from sync: 16 + 8·rxLen + 24.

## Test plan
- Reset: assert rst mid-run -> all outputs 0 within the same cycle, state HUNT. After release, a valid packet still gives syncFound.
- Good packet: air-order bits of 0xAA, 0x8E89BED6, header 0x02,0x06, payload 01 02 03 04 05 06, correct CRC, strobes every cycle -> syncFound, 8 rxByteValid pulses with bytes 02 06 01..06, rxLen=6, pktDone with crcOk=1.
- Same packet with payload bit 17 flipped -> same byte count, pktDone with crcOk=0.
- Header 0x02,0x30 (48 > 37) -> 2 rxByteValid pulses, lenErr pulse, no pktDone. A following valid packet is received with crcOk=1.
- 100 random bits, then preamble+AA with AA bit 5 flipped, then a correct preamble+AA+packet -> no syncFound on the corrupted one, exactly one syncFound and pktDone on the correct one.
- Zero-length PDU (header 0x02,0x00) with strobes every 3rd cycle and en dropped for 1 cycle before the preamble -> rxLen=0, 2 bytes emitted, pktDone with crcOk=1 40 strobes after sync.
